// File: rtl/seg7_pattern_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seg7_pattern_decoder                                               |
// | Samples an active-low 7-segment bus, waits for a stable pattern,   |
// | decodes it to a hex digit, flags illegal patterns, and keeps a     |
// | four-digit history of accepted digits.                             |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module seg7_pattern_decoder #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [6:0]       seg_in,
   input  logic             clear,
   output logic [3:0]       digit_out,
   output logic             digit_valid,
   output logic             digit_strobe,
   output logic             blank,
   output logic             err_illegal,
   output logic [CNT_W-1:0] err_count,
   output logic [15:0]      history
);

   localparam logic [7:0] C_STABLE = 8'(STABLE_CYCLES);
   localparam logic [6:0] C_BLANK  = 7'b1111111;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SETTLING = 2'd1,
      ST_COMMIT   = 2'd2,
      ST_LOCKED   = 2'd3
   } state_t;

   logic [6:0]       r_s1, r_s2, r_prev;
   logic [7:0]       r_run;
   state_t           r_state, w_next_state;
   logic             w_changed, w_commit;
   logic [7:0]       w_run;
   logic [3:0]       w_value;
   logic             w_legal, w_is_blank;

   logic [3:0]       r_digit;
   logic             r_valid, r_strobe, r_blank, r_err;
   logic [CNT_W-1:0] r_err_count;
   logic [15:0]      r_history;

   // Two-flop synchronizer plus a one-cycle-delayed copy for change detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1   <= C_BLANK;
         r_s2   <= C_BLANK;
         r_prev <= C_BLANK;
      end else begin
         r_s1   <= seg_in;
         r_s2   <= r_s1;
         r_prev <= r_s2;
      end
   end

   // Run length including the current sample; the commit decision uses this
   // combinational value so the strobe lands 2 + STABLE_CYCLES edges after a change
   always_comb begin
      w_changed = (r_s2 != r_prev);
      if (w_changed)
         w_run = 8'd1;
      else if (r_run >= C_STABLE)
         w_run = C_STABLE;
      else
         w_run = r_run + 8'd1;
   end

   // Run counter register; clear restarts the count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_run <= 8'd0;
      else if (clear)
         r_run <= 8'd0;
      else
         r_run <= w_run;
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= ST_IDLE;
      else
         r_state <= w_next_state;
   end

   // Next-state logic; COMMIT is occupied during the cycle the accepted outputs appear
   always_comb begin
      w_next_state = r_state;
      w_commit     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // IDLE silently absorbs a run that is already on the bus
            if (w_changed)
               w_next_state = ST_SETTLING;
            else if (w_run == C_STABLE)
               w_next_state = ST_LOCKED;
         end
         ST_SETTLING: begin
            if (w_run == C_STABLE) begin
               w_next_state = ST_COMMIT;
               w_commit     = 1'b1;
            end
         end
         ST_COMMIT: begin
            w_next_state = w_changed ? ST_SETTLING : ST_LOCKED;
         end
         ST_LOCKED: begin
            if (w_changed)
               w_next_state = ST_SETTLING;
         end
         default: w_next_state = ST_IDLE;
      endcase
      if (clear) begin
         w_next_state = ST_IDLE;
         w_commit     = 1'b0;
      end
   end

   // Active-low pattern to hex value decode
   always_comb begin
      w_value    = 4'h0;
      w_legal    = 1'b1;
      w_is_blank = 1'b0;
      case (r_s2)
         7'b1000000: w_value = 4'h0;
         7'b1111001: w_value = 4'h1;
         7'b0100100: w_value = 4'h2;
         7'b0110000: w_value = 4'h3;
         7'b0011001: w_value = 4'h4;
         7'b0010010: w_value = 4'h5;
         7'b0000010: w_value = 4'h6;
         7'b1111000: w_value = 4'h7;
         7'b0000000: w_value = 4'h8;
         7'b0010000: w_value = 4'h9;
         7'b0001000: w_value = 4'hA;
         7'b0000011: w_value = 4'hB;
         7'b1000110: w_value = 4'hC;
         7'b0100001: w_value = 4'hD;
         7'b0000110: w_value = 4'hE;
         7'b0001110: w_value = 4'hF;
         7'b1111111: begin
            w_legal    = 1'b0;
            w_is_blank = 1'b1;
         end
         default: w_legal = 1'b0;
      endcase
   end

   // Output registers: commit actions, clear, and one-cycle strobe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_digit     <= 4'h0;
         r_valid     <= 1'b0;
         r_strobe    <= 1'b0;
         r_blank     <= 1'b1;
         r_err       <= 1'b0;
         r_err_count <= '0;
         r_history   <= 16'h0000;
      end else begin
         r_strobe <= 1'b0;
         if (clear) begin
            r_err       <= 1'b0;
            r_err_count <= '0;
            r_history   <= 16'h0000;
         end else if (w_commit) begin
            if (w_legal) begin
               r_digit   <= w_value;
               r_valid   <= 1'b1;
               r_blank   <= 1'b0;
               r_strobe  <= 1'b1;
               r_history <= {r_history[11:0], w_value};
            end else if (w_is_blank) begin
               r_valid <= 1'b0;
               r_blank <= 1'b1;
            end else begin
               r_valid <= 1'b0;
               r_blank <= 1'b0;
               r_err   <= 1'b1;
               if (r_err_count != {CNT_W{1'b1}})
                  r_err_count <= r_err_count + CNT_W'(1);
            end
         end
      end
   end

   assign digit_out    = r_digit;
   assign digit_valid  = r_valid;
   assign digit_strobe = r_strobe;
   assign blank        = r_blank;
   assign err_illegal  = r_err;
   assign err_count    = r_err_count;
   assign history      = r_history;

endmodule
`default_nettype wire

// File: tb/tb_seg7_pattern_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_seg7_pattern_decoder                                            |
// | Directed vector table, latency/reset sequences, and randomized     |
// | stimulus checked cycle-by-cycle against a behavioural model.       |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module tb_seg7_pattern_decoder;

   localparam int S = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] seg_in = 7'h7F;
   logic       clear = 1'b0;
   logic [3:0] digit_out;
   logic       digit_valid, digit_strobe, blank, err_illegal;
   logic [7:0] err_count;
   logic [15:0] history;

   seg7_pattern_decoder #(.STABLE_CYCLES(S), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .clear(clear),
      .digit_out(digit_out), .digit_valid(digit_valid),
      .digit_strobe(digit_strobe), .blank(blank),
      .err_illegal(err_illegal), .err_count(err_count), .history(history)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;
   int n_strobe = 0;
   bit mon_en = 1'b0;

   logic [6:0] PAT [16];

   // Return the digit a pattern shows, -1 for blank, -2 for illegal
   function automatic int lookup(input logic [6:0] p);
      for (int i = 0; i < 16; i++)
         if (PAT[i] == p) return i;
      if (p == 7'h7F) return -1;
      return -2;
   endfunction

   // ---------------- behavioural model ----------------
   logic [6:0] m_d1 = 7'h7F, m_d2 = 7'h7F, m_last = 7'h7F;
   int         m_run = 0;
   bit         m_consumed = 1'b1;
   logic [3:0] e_digit = 4'h0;
   logic       e_valid = 1'b0, e_strobe = 1'b0, e_blank = 1'b1, e_err = 1'b0;
   logic [7:0] e_cnt = 8'h00;
   logic [15:0] e_hist = 16'h0000;

   always @(posedge clk or negedge rst_n) begin
      logic [6:0] cur;
      int idx;
      if (!rst_n) begin
         m_d1 = 7'h7F; m_d2 = 7'h7F; m_last = 7'h7F;
         m_run = 0; m_consumed = 1'b1;
         e_digit = 4'h0; e_valid = 1'b0; e_strobe = 1'b0; e_blank = 1'b1;
         e_err = 1'b0; e_cnt = 8'h00; e_hist = 16'h0000;
      end else begin
         // the pattern seen by the decoder lags seg_in by two samples
         cur  = m_d2;
         m_d2 = m_d1;
         m_d1 = seg_in;
         if (cur != m_last) begin
            m_run = 1;
            m_consumed = 1'b0;
         end else begin
            m_run++;
         end
         m_last = cur;
         e_strobe = 1'b0;
         if (clear) begin
            e_hist = 16'h0000; e_err = 1'b0; e_cnt = 8'h00;
            m_consumed = 1'b1;
         end else if (m_run == S && !m_consumed) begin
            m_consumed = 1'b1;
            idx = lookup(cur);
            if (idx >= 0) begin
               e_digit = 4'(idx); e_valid = 1'b1; e_blank = 1'b0; e_strobe = 1'b1;
               e_hist = {e_hist[11:0], 4'(idx)};
            end else if (idx == -1) begin
               e_valid = 1'b0; e_blank = 1'b1;
            end else begin
               e_valid = 1'b0; e_blank = 1'b0; e_err = 1'b1;
               if (e_cnt != 8'hFF) e_cnt = e_cnt + 8'd1;
            end
         end
      end
   end

   // Per-cycle comparison against the model and strobe tally
   always @(negedge clk) begin
      logic [31:0] got, exp;
      if (mon_en) begin
         got = {digit_out, digit_valid, digit_strobe, blank, err_illegal, err_count, history};
         exp = {e_digit, e_valid, e_strobe, e_blank, e_err, e_cnt, e_hist};
         n_cmp++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL model t=%0t got=%08h exp=%08h", $time, got, exp);
         end
      end
      if (digit_strobe === 1'b1) n_strobe++;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   typedef struct {
      logic [6:0]  seg;
      int          hold;
      bit          clr;
      logic [3:0]  d;
      bit          v;
      bit          b;
      bit          e;
      logic [7:0]  c;
      logic [15:0] h;
      int          ns;
   } vec_t;

   vec_t tbl [13];

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int base, lat;
      PAT = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

      //          seg         hold clr  d    v  b  e  cnt   hist     strobes
      tbl[0]  = '{7'b1111111, 20,  0, 4'h0, 0, 1, 0, 8'd0, 16'h0000, 0};
      tbl[1]  = '{7'b1111001, 60,  0, 4'h1, 1, 0, 0, 8'd0, 16'h0001, 1};
      tbl[2]  = '{7'b0110000, 10,  0, 4'h3, 1, 0, 0, 8'd0, 16'h0013, 1};
      tbl[3]  = '{7'b0000010, 10,  0, 4'h6, 1, 0, 0, 8'd0, 16'h0136, 1};
      tbl[4]  = '{7'b0001000, 10,  0, 4'hA, 1, 0, 0, 8'd0, 16'h136A, 1};
      tbl[5]  = '{7'b0100001, 10,  0, 4'hD, 1, 0, 0, 8'd0, 16'h36AD, 1};
      tbl[6]  = '{7'b0010010, 10,  0, 4'h5, 1, 0, 0, 8'd0, 16'h6AD5, 1};
      tbl[7]  = '{7'b0000000,  2,  0, 4'h5, 1, 0, 0, 8'd0, 16'h6AD5, 0};
      tbl[8]  = '{7'b0010010, 10,  0, 4'h5, 1, 0, 0, 8'd0, 16'hAD55, 1};
      tbl[9]  = '{7'b0101010, 10,  0, 4'h5, 0, 0, 1, 8'd1, 16'hAD55, 0};
      tbl[10] = '{7'b1010101, 10,  0, 4'h5, 0, 0, 1, 8'd2, 16'hAD55, 0};
      tbl[11] = '{7'b1010101,  1,  1, 4'h5, 0, 0, 0, 8'd0, 16'h0000, 0};
      tbl[12] = '{7'b1010101, 10,  0, 4'h5, 0, 0, 0, 8'd0, 16'h0000, 0};

      repeat (3) @(posedge clk);
      mon_en = 1'b1;
      @(negedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk); #2;

      // Directed table
      for (int i = 0; i < 13; i++) begin
         seg_in = tbl[i].seg;
         clear  = tbl[i].clr;
         base   = n_strobe;
         repeat (tbl[i].hold) @(negedge clk);
         #2;
         clear = 1'b0;
         check($sformatf("vec%0d_outs", i),
               {digit_out, digit_valid, blank, err_illegal, err_count, history},
               {tbl[i].d, tbl[i].v, tbl[i].b, tbl[i].e, tbl[i].c, tbl[i].h});
         check($sformatf("vec%0d_strobes", i), n_strobe - base, tbl[i].ns);
      end

      // Latency: strobe follows the (2+S)-th rising edge after a change
      seg_in = 7'h7F;
      repeat (20) @(negedge clk);
      #2;
      seg_in = 7'b1111001;
      lat = 0;
      for (int k = 1; k <= 50; k++) begin
         @(posedge clk); #1;
         if (digit_strobe === 1'b1) begin
            lat = k;
            break;
         end
      end
      check("latency_edges", lat, 2 + S);
      check("latency_digit", digit_out, 4'h1);

      // Reset mid-settling, then recovery with the same pattern held
      @(negedge clk); #2;
      seg_in = 7'b1111000;
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_reset_outs",
            {digit_out, digit_valid, digit_strobe, blank, err_illegal, err_count, history},
            {4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 16'h0000});
      @(negedge clk); #2;
      rst_n = 1'b1;
      base = n_strobe;
      repeat (20) @(negedge clk);
      #2;
      check("reset_recover_strobes", n_strobe - base, 1);
      check("reset_recover_digit", {digit_out, digit_valid, history}, {4'h7, 1'b1, 16'h0007});

      // Randomized segments against the model
      for (int it = 0; it < 400; it++) begin
         int sel, hold;
         sel = $urandom_range(0, 9);
         if (sel < 6)       seg_in = PAT[$urandom_range(0, 15)];
         else if (sel == 6) seg_in = 7'h7F;
         else if (sel < 9)  seg_in = 7'($urandom_range(0, 127));
         hold  = $urandom_range(1, 9);
         clear = ($urandom_range(0, 15) == 0);
         if (it == 200) begin
            rst_n = 1'b0;
            #2;
            rst_n = 1'b1;
         end
         @(negedge clk); #2;
         clear = 1'b0;
         if (hold > 1) repeat (hold - 1) @(negedge clk);
         #2;
      end

      repeat (5) @(negedge clk);
      #2;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/seg7_pattern_decoder.md
Name: seg7_pattern_decoder

Overview:
- Receive-side counterpart of the lab 7-segment display drivers: samples an active-low 7-segment bus and recovers the hex digit it shows.
- Uses a stability filter, so only patterns held for a programmable number of cycles are accepted.
- Flags illegal patterns and keeps a 4-digit history.
- Used by bench and self-check logic to read back what gate and arithmetic labs drive onto their displays.

Parameters:
- STABLE_CYCLES, 4, consecutive identical synchronized samples needed to accept a pattern; legal range 2..255.
- CNT_W, 8, width of the illegal-pattern counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- seg_in  input  7  active-low segments, bit order {g,f,e,d,c,b,a}; asynchronous to clk.
- clear  input  1  synchronous clear of history, error flag and counter.
- digit_out  output  4  last accepted digit value.
- digit_valid  output  1  last accepted pattern was a legal digit.
- digit_strobe  output  1  one-cycle pulse on each accepted digit.
- blank  output  1  last accepted pattern was all segments off (7'b1111111).
- err_illegal  output  1  sticky flag: an illegal pattern was accepted.
- err_count  output  CNT_W  saturating count of accepted illegal patterns.
- history  output  16  last four accepted digits; [3:0] is newest.

Behaviour:
- Reset values:
  - Synchronizer flops: 7'b1111111.
  - digit_out 0, digit_valid 0, digit_strobe 0, blank 1.
  - err_illegal 0, err_count 0, history 16'h0000.
  - Run counter 0. FSM in IDLE.
- Synchronizer: seg_in passes through 2 flops (s1, s2). Only s2 is used downstream.
- Run tracking:
  - prev holds s2 from the previous cycle.
  - If s2 != prev, the run counter loads 1.
  - Otherwise the counter increments, saturating at STABLE_CYCLES.
- Decode table (active-low), legal digits:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110
  - 1111111 decodes as blank. Every other pattern is illegal.
- FSM states:
  - IDLE: after reset or clear; move to SETTLING on the first s2 change.
  - SETTLING: run counter below STABLE_CYCLES.
  - COMMIT: single cycle, entered when the run counter reaches STABLE_CYCLES.
  - LOCKED: pattern already accepted; no further action until s2 changes, which returns the FSM to SETTLING.
  - IDLE also commits the reset pattern (blank) if it stays stable. The outputs are unchanged in that case.
- COMMIT actions, registered, visible the following cycle:
  - Legal digit: digit_out = value, digit_valid = 1, blank = 0, digit_strobe = 1 for exactly one cycle, history = {history[11:0], value}.
  - Blank: digit_valid = 0, blank = 1, no strobe, history and digit_out hold.
  - Illegal: digit_valid = 0, blank = 0, err_illegal = 1, err_count increments (saturates at all-ones), digit_out and history hold, no strobe.
- One commit per stable run. A pattern held indefinitely commits once. The same digit presented again after any intervening change commits again, with a strobe and a history shift.
- Latency: the first strobe-high cycle follows the (2 + STABLE_CYCLES)-th rising edge after seg_in settles.
- Glitch rejection: any change shorter than STABLE_CYCLES samples restarts the run and produces no commit. The previously accepted outputs hold.
- clear:
  - Zeroes history, err_illegal and err_count, and returns the FSM to IDLE with the run counter at 0.
  - digit_out, digit_valid and blank hold.
  - clear takes priority over a COMMIT in the same cycle: that commit is discarded.
- rst_n assertion at any time, including mid-run, forces all reset values immediately. Operation restarts from IDLE after deassertion.

Test Plan:
- Reset release, seg_in = 1111111 held → blank = 1, digit_valid = 0, no strobe, err_count = 0.
- STABLE_CYCLES = 4, seg_in = 1111001 held → one strobe, 6 edges after the change, digit_out = 1, digit_valid = 1, history = 16'h0001; no second strobe after 50 cycles.
- Drive 0110000, 0000010, 0001000, 0100001 (each held 10 cycles) → 4 strobes, history = 16'h36AD.
- Digit 5 stable, then a 2-cycle glitch to 0000000, then back to 0010010 → no commit of 8; exactly one strobe (the re-commit of 5); history newest nibble 5, previous 5.
- seg_in = 0101010 held, then 1010101 held → err_illegal = 1, err_count = 2, digit_valid = 0, digit_out and history unchanged; then pulse clear → err_count = 0, err_illegal = 0, history = 0.
- Assert rst_n low mid-SETTLING for digit 7 → outputs return to reset values immediately; after release with 1111000 still held → a single strobe with digit_out = 7.
